// File: rtl/if_id_stage_pkg.sv
// Shared constants for the fetch stage: widths, memory depth, NOP encoding and HALT opcode.
package if_id_stage_pkg;
   localparam int NB_WIDTH  = 32;
   localparam int NB_BYTE   = 8;
   localparam int MEM_DEPTH = 256;

   localparam logic [31:0] NOP_WORD    = 32'h0000_0000;
   localparam logic [5:0]  HALT_OPCODE = 6'b111111;

   function automatic logic is_halt(input logic [5:0] opcode);
      return opcode == HALT_OPCODE;
   endfunction
endpackage

// File: rtl/if_id_stage_instr_mem.sv
// Instruction memory: one synchronous write port, one synchronous read port with enable.
module instr_mem
   import if_id_stage_pkg::*;
#(
   parameter int NB_WIDTH  = if_id_stage_pkg::NB_WIDTH,
   parameter int MEM_DEPTH = if_id_stage_pkg::MEM_DEPTH,
   localparam int AW       = $clog2(MEM_DEPTH)
) (
   input  logic                clk,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [NB_WIDTH-1:0] wr_data,
   input  logic                rd_en,
   input  logic [AW-1:0]       rd_addr,
   output logic [NB_WIDTH-1:0] rd_data
);
   logic [NB_WIDTH-1:0] mem [MEM_DEPTH];

   // Non-blocking read of the array gives old contents on a same-address write.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end
endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch stage with IF/ID pipeline register and a byte-serial program loader.
module if_id_stage #(
   parameter int NB_WIDTH  = if_id_stage_pkg::NB_WIDTH,
   parameter int NB_BYTE   = if_id_stage_pkg::NB_BYTE,
   parameter int MEM_DEPTH = if_id_stage_pkg::MEM_DEPTH
) (
   input  logic                clk,
   input  logic                i_rst_n,
   input  logic [NB_WIDTH-1:0] i_pcounter,
   input  logic                i_stall,
   input  logic                i_halt,
   input  logic                i_flush,
   input  logic                i_wr_en,
   input  logic [NB_BYTE-1:0]  i_wr_byte,
   input  logic                i_load_clr,
   output logic [NB_WIDTH-1:0] o_instruction,
   output logic [NB_WIDTH-1:0] o_pcounter4,
   output logic                o_valid,
   output logic                o_halt_fetched,
   output logic [NB_WIDTH-1:0] o_words_loaded
);
   import if_id_stage_pkg::*;

   localparam int AW    = $clog2(MEM_DEPTH);
   localparam int BYTES = NB_WIDTH / NB_BYTE;
   localparam int CW    = $clog2(BYTES);

   logic [CW-1:0]       byte_cnt;
   logic [AW-1:0]       wr_ptr;
   logic [NB_WIDTH-1:0] assembly;
   logic [NB_WIDTH-1:0] word_next;
   logic [NB_WIDTH-1:0] words_loaded;
   logic [NB_WIDTH-1:0] pcounter4;
   logic [NB_WIDTH-1:0] mem_data;
   logic                valid;
   logic                word_done;
   logic                fetch_en;

   assign word_next = {assembly[NB_WIDTH-NB_BYTE-1:0], i_wr_byte};
   assign word_done = i_wr_en && !i_load_clr && (byte_cnt == CW'(BYTES - 1));
   assign fetch_en  = !i_halt && !i_stall;

   // The memory read register doubles as the IF/ID instruction register; it freezes on halt/stall.
   instr_mem #(
      .NB_WIDTH (NB_WIDTH),
      .MEM_DEPTH(MEM_DEPTH)
   ) u_instr_mem (
      .clk    (clk),
      .wr_en  (word_done),
      .wr_addr(wr_ptr),
      .wr_data(word_next),
      .rd_en  (fetch_en),
      .rd_addr(i_pcounter[AW+1:2]),
      .rd_data(mem_data)
   );

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pcounter4 <= '0;
         valid     <= 1'b0;
      end else if (i_flush) begin
         pcounter4 <= '0;
         valid     <= 1'b0;
      end else if (fetch_en) begin
         pcounter4 <= i_pcounter + NB_WIDTH'(4);
         valid     <= 1'b1;
      end
   end

   // A cleared valid bit masks the unreset memory read data, so flush and reset both yield a NOP.
   assign o_instruction  = valid ? mem_data : NB_WIDTH'(NOP_WORD);
   assign o_pcounter4    = pcounter4;
   assign o_valid        = valid;
   assign o_halt_fetched = valid && is_halt(o_instruction[NB_WIDTH-1 -: 6]);
   assign o_words_loaded = words_loaded;

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         byte_cnt     <= '0;
         wr_ptr       <= '0;
         assembly     <= '0;
         words_loaded <= '0;
      end else if (i_load_clr) begin
         byte_cnt     <= '0;
         wr_ptr       <= '0;
         assembly     <= '0;
         words_loaded <= '0;
      end else if (i_wr_en) begin
         assembly <= word_next;
         byte_cnt <= byte_cnt + CW'(1);
         if (word_done) begin
            wr_ptr       <= wr_ptr + AW'(1);
            words_loaded <= words_loaded + NB_WIDTH'(1);
         end
      end
   end
endmodule
